// File: rtl/ula_mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit that sits beside the ULA.
// Operation codes match the op field driven by the control unit.
package pkg_mult_div;

   localparam int LARGURA_PADRAO = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      CALCULA = 2'b01,
      CORRIGE = 2'b10
   } estado_t;

endpackage

// File: rtl/ula_mult_div_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is the master; the unit itself uses the slave view.
interface ula_mult_div_if #(
   parameter int LARGURA = 32
);
   logic [LARGURA-1:0] operando_a;
   logic [LARGURA-1:0] operando_b;
   logic [1:0]         op;
   logic               inicio;
   logic               ocupado;
   logic               pronto;
   logic               div_zero;
   logic [LARGURA-1:0] hi;
   logic [LARGURA-1:0] lo;

   modport master (
      output operando_a, operando_b, op, inicio,
      input  ocupado, pronto, div_zero, hi, lo
   );

   modport slave (
      input  operando_a, operando_b, op, inicio,
      output ocupado, pronto, div_zero, hi, lo
   );
endinterface

// File: rtl/ula_mult_div_passo.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// shift-subtract for divide. acc holds {upper half, lower half} in both modes.
module mult_div_passo #(
   parameter int LARGURA = 32
) (
   input  logic                 eh_divisao,
   input  logic [2*LARGURA-1:0] acc,
   input  logic [LARGURA-1:0]   operando,
   output logic [2*LARGURA-1:0] acc_prox
);

   logic [LARGURA:0] soma;
   logic [LARGURA:0] tentativa;

   // Divide: the upper half is the partial remainder and the dividend shifts out of the
   // lower half while quotient bits shift in. A borrow in bit LARGURA means restore.
   always_comb begin
      soma      = {1'b0, acc[2*LARGURA-1:LARGURA]} + {1'b0, operando};
      tentativa = {acc[2*LARGURA-1:LARGURA], acc[LARGURA-1]} - {1'b0, operando};
      acc_prox  = acc;
      if (eh_divisao) begin
         if (tentativa[LARGURA])
            acc_prox = {acc[2*LARGURA-2:0], 1'b0};
         else
            acc_prox = {tentativa[LARGURA-1:0], acc[LARGURA-2:0], 1'b1};
      end else begin
         if (acc[0])
            acc_prox = {soma, acc[LARGURA-1:1]};
         else
            acc_prox = {1'b0, acc[2*LARGURA-1:1]};
      end
   end

endmodule

// File: rtl/ula_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 unsigned iterations on operand magnitudes,
// then one sign-correction cycle that writes HI/LO. ocupado stalls the pipeline meanwhile.
module ula_mult_div
   import pkg_mult_div::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input logic           clock,
   input logic           reset,
   ula_mult_div_if.slave bus
);

   localparam int LARG_CONT = $clog2(LARGURA);
   localparam logic [LARG_CONT-1:0] ULTIMO = LARG_CONT'(LARGURA - 1);

   estado_t                estado, estado_prox;
   op_t                    op_reg;
   logic [LARG_CONT-1:0]   contador;
   logic                   sinal_a, sinal_b;
   logic [LARGURA-1:0]     operando_reg;
   logic [2*LARGURA-1:0]   acc, acc_prox;
   logic [LARGURA-1:0]     hi_reg, lo_reg;
   logic                   pronto_reg, div_zero_reg;

   logic                   eh_div_in, com_sinal_in, zero_in;
   logic                   sinal_a_in, sinal_b_in;
   logic [LARGURA-1:0]     mag_a, mag_b;
   logic [2*LARGURA-1:0]   produto;
   logic [LARGURA-1:0]     quociente, resto;
   logic                   eh_div_reg;

   // Incoming operands are reduced to magnitudes; 0x80000000 negates to itself,
   // which read as unsigned is exactly 2^31.
   always_comb begin
      eh_div_in    = bus.op[1];
      com_sinal_in = ~bus.op[0];
      sinal_a_in   = com_sinal_in & bus.operando_a[LARGURA-1];
      sinal_b_in   = com_sinal_in & bus.operando_b[LARGURA-1];
      mag_a        = sinal_a_in ? -bus.operando_a : bus.operando_a;
      mag_b        = sinal_b_in ? -bus.operando_b : bus.operando_b;
      zero_in      = eh_div_in && (bus.operando_b == '0);
   end

   assign eh_div_reg = (op_reg == OP_DIV) || (op_reg == OP_DIVU);

   mult_div_passo #(.LARGURA(LARGURA)) u_passo (
      .eh_divisao (eh_div_reg),
      .acc        (acc),
      .operando   (operando_reg),
      .acc_prox   (acc_prox)
   );

   // Signs are latched only for signed ops, so these reduce to identity for unsigned ones.
   always_comb begin
      produto   = (sinal_a ^ sinal_b) ? -acc : acc;
      quociente = (sinal_a ^ sinal_b) ? -acc[LARGURA-1:0] : acc[LARGURA-1:0];
      resto     = sinal_a ? -acc[2*LARGURA-1:LARGURA] : acc[2*LARGURA-1:LARGURA];
   end

   always_ff @(posedge clock) begin
      if (!reset)
         estado <= OCIOSO;
      else
         estado <= estado_prox;
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:  if (bus.inicio) estado_prox = zero_in ? CORRIGE : CALCULA;
         CALCULA: if (contador == ULTIMO) estado_prox = CORRIGE;
         CORRIGE: estado_prox = OCIOSO;
         default: estado_prox = OCIOSO;
      endcase
   end

   // Divide by zero keeps the raw dividend in the low half so it can be returned on HI.
   always_ff @(posedge clock) begin
      if (!reset) begin
         op_reg       <= OP_MULT;
         contador     <= '0;
         sinal_a      <= 1'b0;
         sinal_b      <= 1'b0;
         operando_reg <= '0;
         acc          <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         pronto_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         pronto_reg <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (bus.inicio) begin
                  op_reg       <= op_t'(bus.op);
                  contador     <= '0;
                  sinal_a      <= sinal_a_in;
                  sinal_b      <= sinal_b_in;
                  operando_reg <= mag_b;
                  acc          <= {{LARGURA{1'b0}}, (zero_in ? bus.operando_a : mag_a)};
                  div_zero_reg <= zero_in;
               end
            end
            CALCULA: begin
               acc      <= acc_prox;
               contador <= contador + LARG_CONT'(1);
            end
            CORRIGE: begin
               pronto_reg <= 1'b1;
               if (div_zero_reg) begin
                  hi_reg <= acc[LARGURA-1:0];
                  lo_reg <= '1;
               end else if (eh_div_reg) begin
                  hi_reg <= resto;
                  lo_reg <= quociente;
               end else begin
                  hi_reg <= produto[2*LARGURA-1:LARGURA];
                  lo_reg <= produto[LARGURA-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ocupado  = (estado != OCIOSO);
   assign bus.pronto   = pronto_reg;
   assign bus.div_zero = div_zero_reg;
   assign bus.hi       = hi_reg;
   assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_ula_mult_div.sv
// Self-checking bench for ula_mult_div: table of directed operations with hand-computed
// HI/LO, then hand-written sequences for busy-time inicio and mid-operation reset.
module tb_ula_mult_div;
   import pkg_mult_div::*;

   logic clock = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   ula_mult_div_if #(.LARGURA(32)) bus ();

   ula_mult_div #(.LARGURA(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      op_t         op;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dz;
      int          exp_ciclos;
   } vetor_t;

   vetor_t vetores[10];

   task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      compared++;
      if (atual !== esperado) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", nome, atual, esperado);
      end
   endtask

   // Issues one operation at a negedge and counts ocupado cycles until it drops.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input op_t o,
                                output int ciclos, output logic pr, output logic dz,
                                output logic [31:0] h, output logic [31:0] l);
      bus.operando_a = a;
      bus.operando_b = b;
      bus.op         = o;
      bus.inicio     = 1'b1;
      @(negedge clock);
      bus.inicio     = 1'b0;
      bus.operando_a = $urandom;
      bus.operando_b = $urandom;
      ciclos = 0;
      while (bus.ocupado && ciclos < 100) begin
         ciclos++;
         @(negedge clock);
      end
      pr = bus.pronto;
      dz = bus.div_zero;
      h  = bus.hi;
      l  = bus.lo;
   endtask

   initial begin
      int          ciclos;
      logic        pr, dz;
      logic [31:0] h, l;

      reset = 1'b0;
      bus.inicio = 1'b0;
      bus.operando_a = '0;
      bus.operando_b = '0;
      bus.op = OP_MULT;
      repeat (2) @(negedge clock);
      checkOutput("reset_ocupado", 32'(bus.ocupado), 32'd0);
      checkOutput("reset_pronto", 32'(bus.pronto), 32'd0);
      checkOutput("reset_div_zero", 32'(bus.div_zero), 32'd0);
      checkOutput("reset_hi", bus.hi, 32'd0);
      checkOutput("reset_lo", bus.lo, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      vetores[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULTU, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
      vetores[1] = '{32'hFFFFFFFD, 32'h00000007, OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
      vetores[2] = '{32'hFFFFFFF9, 32'h00000002, OP_DIV,   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
      vetores[3] = '{32'd100,      32'd7,        OP_DIVU,  32'd2,        32'd14,       1'b0, 33};
      vetores[4] = '{32'h00000064, 32'h00000000, OP_DIVU,  32'h00000064, 32'hFFFFFFFF, 1'b1, 1};
      vetores[5] = '{32'h80000000, 32'hFFFFFFFF, OP_DIV,   32'h00000000, 32'h80000000, 1'b0, 33};
      vetores[6] = '{32'h80000000, 32'h80000000, OP_MULT,  32'h40000000, 32'h00000000, 1'b0, 33};
      vetores[7] = '{32'h00000007, 32'hFFFFFFFE, OP_DIV,   32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
      vetores[8] = '{32'h12345678, 32'h00000010, OP_MULTU, 32'h00000001, 32'h23456780, 1'b0, 33};
      vetores[9] = '{32'hFFFFFFF6, 32'h00000000, OP_DIV,   32'hFFFFFFF6, 32'hFFFFFFFF, 1'b1, 1};

      // Back-to-back: each new inicio lands in the pronto cycle of the previous op.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vetores[i].a, vetores[i].b, vetores[i].op, ciclos, pr, dz, h, l);
         checkOutput($sformatf("v%0d_ciclos", i), 32'(ciclos), 32'(vetores[i].exp_ciclos));
         checkOutput($sformatf("v%0d_pronto", i), 32'(pr), 32'd1);
         checkOutput($sformatf("v%0d_div_zero", i), 32'(dz), 32'(vetores[i].exp_dz));
         checkOutput($sformatf("v%0d_hi", i), h, vetores[i].exp_hi);
         checkOutput($sformatf("v%0d_lo", i), l, vetores[i].exp_lo);
      end

      // inicio during a busy DIVU must be dropped, not queued.
      @(negedge clock);
      bus.operando_a = 32'd100;
      bus.operando_b = 32'd7;
      bus.op = OP_DIVU;
      bus.inicio = 1'b1;
      @(negedge clock);
      bus.inicio = 1'b0;
      ciclos = 0;
      while (bus.ocupado && ciclos < 100) begin
         if (ciclos == 10) begin
            bus.operando_a = 32'd3;
            bus.operando_b = 32'd5;
            bus.op = OP_MULTU;
            bus.inicio = 1'b1;
         end else begin
            bus.inicio = 1'b0;
         end
         ciclos++;
         @(negedge clock);
      end
      bus.inicio = 1'b0;
      checkOutput("busy_ciclos", 32'(ciclos), 32'd33);
      checkOutput("busy_pronto", 32'(bus.pronto), 32'd1);
      checkOutput("busy_hi", bus.hi, 32'd2);
      checkOutput("busy_lo", bus.lo, 32'd14);
      @(negedge clock);
      checkOutput("busy_pronto_pulse", 32'(bus.pronto), 32'd0);
      checkOutput("busy_no_queue", 32'(bus.ocupado), 32'd0);
      checkOutput("busy_hi_hold", bus.hi, 32'd2);

      // Reset one edge into a MULT, at cycle 15 of the operation.
      bus.operando_a = 32'hFFFFFFFD;
      bus.operando_b = 32'd7;
      bus.op = OP_MULT;
      bus.inicio = 1'b1;
      @(negedge clock);
      bus.inicio = 1'b0;
      repeat (14) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      checkOutput("midreset_ocupado", 32'(bus.ocupado), 32'd0);
      checkOutput("midreset_pronto", 32'(bus.pronto), 32'd0);
      checkOutput("midreset_hi", bus.hi, 32'd0);
      checkOutput("midreset_lo", bus.lo, 32'd0);
      @(negedge clock);
      checkOutput("midreset_still_idle", 32'(bus.ocupado), 32'd0);

      applyStimulus(32'd3, 32'd5, OP_MULTU, ciclos, pr, dz, h, l);
      checkOutput("after_reset_ciclos", 32'(ciclos), 32'd33);
      checkOutput("after_reset_pronto", 32'(pr), 32'd1);
      checkOutput("after_reset_hi", h, 32'd0);
      checkOutput("after_reset_lo", l, 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
